// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if
// Bundles the decode-side handshake and the datapath control outputs of the
// ALU sequencer so that decode, sequencer and bench share one connection.
//   Decode -> sequencer : start, op_class[2:0], alu_func[2:0], zero
//   Sequencer -> datapath: alu_src_a[1:0], alu_src_b[1:0], alu_op[2:0],
//                          pc_write, ir_write, alu_out_write, reg_write,
//                          pc_src, busy, done, error
// The master modport is the decode side; the slave modport is the sequencer.
interface alu_seq_ctrl_if;
   logic       start;
   logic [2:0] op_class;
   logic [2:0] alu_func;
   logic       zero;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_op;
   logic       pc_write;
   logic       ir_write;
   logic       alu_out_write;
   logic       reg_write;
   logic       pc_src;
   logic       busy;
   logic       done;
   logic       error;

   modport master (
      output start, op_class, alu_func, zero,
      input  alu_src_a, alu_src_b, alu_op, pc_write, ir_write,
             alu_out_write, reg_write, pc_src, busy, done, error
   );

   modport slave (
      input  start, op_class, alu_func, zero,
      output alu_src_a, alu_src_b, alu_op, pc_write, ir_write,
             alu_out_write, reg_write, pc_src, busy, done, error
   );
endinterface

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl
// Multicycle sequencer driving the ALU source selects, ALU operation and the
// register write strobes for one instruction per start/done handshake.
// Ports:
//   clk    - system clock, all state changes on the rising edge
//   reset  - synchronous active-high reset, returns to IDLE with outputs 0
//   bus    - alu_seq_ctrl_if.slave: start/op_class/alu_func/zero in,
//            selects, alu_op, strobes, pc_src, busy, done, error out
// Sequences (start sampled in IDLE):
//   ALU classes 0/1/2/4 : FETCH, DECODE, EXEC, WB, DONE
//   branch class 3      : FETCH, DECODE, BRANCH, DONE
//   illegal classes 5-7 : FETCH, DECODE, ERR
module alu_seq_ctrl (
   input  logic          clk,
   input  logic          reset,
   alu_seq_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_WB,
      S_BRANCH,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [2:0] OP_ADD    = 3'd0;
   localparam logic [2:0] OP_SUB    = 3'd1;
   localparam logic [2:0] OP_PASS_A = 3'd4;

   state_t     state_q;
   state_t     state_nxt;
   logic [2:0] cls_q;
   logic [2:0] cls_nxt;
   logic [2:0] fn_q;
   logic [2:0] fn_nxt;

   logic [1:0] src_a_q, src_a_nxt;
   logic [1:0] src_b_q, src_b_nxt;
   logic [2:0] alu_op_q, alu_op_nxt;
   logic       pc_write_q, pc_write_nxt;
   logic       ir_write_q, ir_write_nxt;
   logic       alu_out_write_q, alu_out_write_nxt;
   logic       reg_write_q, reg_write_nxt;
   logic       pc_src_q, pc_src_nxt;
   logic       busy_q, busy_nxt;
   logic       done_q, done_nxt;
   logic       error_q, error_nxt;

   // Next-state selection. The instruction class and ALU function are only
   // captured on the way out of DECODE and held until the next DECODE, so
   // changes on op_class/alu_func at any other time have no effect.
   always_comb begin
      state_nxt = state_q;
      cls_nxt   = cls_q;
      fn_nxt    = fn_q;
      case (state_q)
         S_IDLE:   if (bus.start) state_nxt = S_FETCH;
         S_FETCH:  state_nxt = S_DECODE;
         S_DECODE: begin
            cls_nxt = bus.op_class;
            fn_nxt  = bus.alu_func;
            case (bus.op_class)
               3'd0, 3'd1, 3'd2, 3'd4: state_nxt = S_EXEC;
               3'd3:                   state_nxt = S_BRANCH;
               default:                state_nxt = S_ERR;
            endcase
         end
         S_EXEC:   state_nxt = S_WB;
         S_WB:     state_nxt = S_DONE;
         S_BRANCH: state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         S_ERR:    state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Output decode for the state about to be entered. Registering these
   // values alongside the state gives Moore outputs with no decode glitches.
   // EXEC uses the class/function being latched on the same edge, so the
   // first EXEC cycle already reflects the freshly decoded instruction.
   always_comb begin
      src_a_nxt         = 2'd0;
      src_b_nxt         = 2'd0;
      alu_op_nxt        = OP_ADD;
      pc_write_nxt      = 1'b0;
      ir_write_nxt      = 1'b0;
      alu_out_write_nxt = 1'b0;
      reg_write_nxt     = 1'b0;
      pc_src_nxt        = 1'b0;
      done_nxt          = 1'b0;
      error_nxt         = 1'b0;
      busy_nxt          = (state_nxt != S_IDLE);
      case (state_nxt)
         S_FETCH: begin
            src_b_nxt    = 2'd1;
            pc_write_nxt = 1'b1;
            ir_write_nxt = 1'b1;
         end
         S_DECODE: begin
            src_b_nxt         = 2'd3;
            alu_out_write_nxt = 1'b1;
         end
         S_EXEC: begin
            alu_out_write_nxt = 1'b1;
            case (cls_nxt)
               3'd0: begin
                  src_a_nxt  = 2'd1;
                  alu_op_nxt = fn_nxt;
               end
               3'd1: begin
                  src_a_nxt  = 2'd1;
                  src_b_nxt  = 2'd2;
                  alu_op_nxt = fn_nxt;
               end
               3'd2: begin
                  src_a_nxt  = 2'd2;
                  alu_op_nxt = OP_PASS_A;
               end
               3'd4: begin
                  src_a_nxt = 2'd3;
                  src_b_nxt = 2'd1;
               end
               default: begin
                  src_a_nxt = 2'd0;
               end
            endcase
         end
         S_WB:     reg_write_nxt = 1'b1;
         S_BRANCH: begin
            src_a_nxt  = 2'd1;
            alu_op_nxt = OP_SUB;
            pc_src_nxt = 1'b1;
         end
         S_DONE:   done_nxt  = 1'b1;
         S_ERR:    error_nxt = 1'b1;
         default:  busy_nxt  = (state_nxt != S_IDLE);
      endcase
   end

   // State, latched instruction fields and registered outputs. Reset wins
   // over everything, abandoning any in-flight instruction immediately.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= S_IDLE;
         cls_q           <= 3'd0;
         fn_q            <= 3'd0;
         src_a_q         <= 2'd0;
         src_b_q         <= 2'd0;
         alu_op_q        <= 3'd0;
         pc_write_q      <= 1'b0;
         ir_write_q      <= 1'b0;
         alu_out_write_q <= 1'b0;
         reg_write_q     <= 1'b0;
         pc_src_q        <= 1'b0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         error_q         <= 1'b0;
      end else begin
         state_q         <= state_nxt;
         cls_q           <= cls_nxt;
         fn_q            <= fn_nxt;
         src_a_q         <= src_a_nxt;
         src_b_q         <= src_b_nxt;
         alu_op_q        <= alu_op_nxt;
         pc_write_q      <= pc_write_nxt;
         ir_write_q      <= ir_write_nxt;
         alu_out_write_q <= alu_out_write_nxt;
         reg_write_q     <= reg_write_nxt;
         pc_src_q        <= pc_src_nxt;
         busy_q          <= busy_nxt;
         done_q          <= done_nxt;
         error_q         <= error_nxt;
      end
   end

   // The branch PC write depends on the live ALU zero flag of the compare
   // being performed in BRANCH, so it is the one output not fully registered.
   always_comb begin
      bus.pc_write = pc_write_q | ((state_q == S_BRANCH) & bus.zero);
   end

   assign bus.alu_src_a     = src_a_q;
   assign bus.alu_src_b     = src_b_q;
   assign bus.alu_op        = alu_op_q;
   assign bus.ir_write      = ir_write_q;
   assign bus.alu_out_write = alu_out_write_q;
   assign bus.reg_write     = reg_write_q;
   assign bus.pc_src        = pc_src_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.error         = error_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl
// Directed bench for alu_seq_ctrl. Outputs are packed into one vector
// {src_a, src_b, alu_op, pc_write, ir_write, alu_out_write, reg_write,
//  pc_src, busy, done, error} and compared against hand-built constants.
module tb_alu_seq_ctrl;
   logic clk;
   logic reset;
   int   checks;
   int   failures;

   alu_seq_ctrl_if bus ();

   alu_seq_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pack the expected output vector from its individual fields.
   function automatic logic [14:0] expv(
      input logic [1:0] a, input logic [1:0] b, input logic [2:0] op,
      input logic pw, input logic iw, input logic aw, input logic rw,
      input logic ps, input logic bu, input logic dn, input logic er);
      return {a, b, op, pw, iw, aw, rw, ps, bu, dn, er};
   endfunction

   function automatic logic [14:0] observed();
      return {bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_write,
              bus.ir_write, bus.alu_out_write, bus.reg_write, bus.pc_src,
              bus.busy, bus.done, bus.error};
   endfunction

   // Single comparison point: counts and reports every check.
   task automatic checkOutput(input string tag, input logic [14:0] obs,
                              input logic [14:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic st, input logic [2:0] cls,
                                input logic [2:0] fn, input logic z);
      bus.start    = st;
      bus.op_class = cls;
      bus.alu_func = fn;
      bus.zero     = z;
   endtask

   // Advance one cycle and settle 1 ns past the edge before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [14:0] idleV, fetchV, decodeV, wbV, doneV, errV;

   initial begin
      checks   = 0;
      failures = 0;
      idleV    = expv(2'd0, 2'd0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
      fetchV   = expv(2'd0, 2'd1, 3'd0, 1, 1, 0, 0, 0, 1, 0, 0);
      decodeV  = expv(2'd0, 2'd3, 3'd0, 0, 0, 1, 0, 0, 1, 0, 0);
      wbV      = expv(2'd0, 2'd0, 3'd0, 0, 0, 0, 1, 0, 1, 0, 0);
      doneV    = expv(2'd0, 2'd0, 3'd0, 0, 0, 0, 0, 0, 1, 1, 0);
      errV     = expv(2'd0, 2'd0, 3'd0, 0, 0, 0, 0, 0, 1, 0, 1);

      reset = 1'b1;
      applyStimulus(0, 3'd0, 3'd0, 0);
      tick();
      tick();
      reset = 1'b0;
      checkOutput("reset_idle", observed(), idleV);

      // R-type, alu_func 3
      applyStimulus(1, 3'd0, 3'd3, 0);
      tick(); bus.start = 0;
      checkOutput("r_fetch", observed(), fetchV);
      tick(); checkOutput("r_decode", observed(), decodeV);
      tick(); checkOutput("r_exec", observed(), expv(2'd1, 2'd0, 3'd3, 0, 0, 1, 0, 0, 1, 0, 0));
      tick(); checkOutput("r_wb", observed(), wbV);
      tick(); checkOutput("r_done", observed(), doneV);
      tick(); checkOutput("r_idle", observed(), idleV);

      // NOT
      applyStimulus(1, 3'd2, 3'd1, 0);
      tick(); bus.start = 0;
      tick();
      tick(); checkOutput("not_exec", observed(), expv(2'd2, 2'd0, 3'd4, 0, 0, 1, 0, 0, 1, 0, 0));
      tick(); checkOutput("not_wb", observed(), wbV);
      tick(); checkOutput("not_done", observed(), doneV);
      tick();

      // Branch taken, then zero dropped within the same cycle
      applyStimulus(1, 3'd3, 3'd0, 0);
      tick(); bus.start = 0;
      tick(); bus.zero = 1;
      tick(); checkOutput("beq_taken", observed(), expv(2'd1, 2'd0, 3'd1, 1, 0, 0, 0, 1, 1, 0, 0));
      bus.zero = 0; #1;
      checkOutput("beq_zero_live", observed(), expv(2'd1, 2'd0, 3'd1, 0, 0, 0, 0, 1, 1, 0, 0));
      tick(); checkOutput("beq_done", observed(), doneV);
      tick();

      // Branch not taken
      applyStimulus(1, 3'd3, 3'd0, 0);
      tick(); bus.start = 0;
      tick();
      tick(); checkOutput("beq_not_taken", observed(), expv(2'd1, 2'd0, 3'd1, 0, 0, 0, 0, 1, 1, 0, 0));
      tick(); checkOutput("beq_nt_done", observed(), doneV);
      tick();

      // Illegal class, then a legal ALU-immediate
      applyStimulus(1, 3'd6, 3'd0, 0);
      tick(); bus.start = 0;
      tick();
      tick(); checkOutput("ill_error", observed(), errV);
      tick(); checkOutput("ill_idle", observed(), idleV);
      applyStimulus(1, 3'd1, 3'd2, 0);
      tick(); bus.start = 0;
      checkOutput("imm_fetch", observed(), fetchV);
      tick();
      tick(); checkOutput("imm_exec", observed(), expv(2'd1, 2'd2, 3'd2, 0, 0, 1, 0, 0, 1, 0, 0));
      tick(); checkOutput("imm_wb", observed(), wbV);
      tick(); checkOutput("imm_done", observed(), doneV);
      tick();

      // Reset in EXEC
      applyStimulus(1, 3'd0, 3'd1, 0);
      tick(); bus.start = 0;
      tick();
      tick(); reset = 1;
      tick(); reset = 0;
      checkOutput("reset_mid", observed(), idleV);
      tick(); checkOutput("reset_mid_stay", observed(), idleV);

      // start pulsed while busy and held through DONE
      applyStimulus(1, 3'd0, 3'd2, 0);
      tick(); bus.start = 0;
      tick(); bus.start = 1;
      tick(); checkOutput("busy_start_exec", observed(), expv(2'd1, 2'd0, 3'd2, 0, 0, 1, 0, 0, 1, 0, 0));
      bus.start = 0;
      tick(); bus.start = 1;
      checkOutput("busy_start_wb", observed(), wbV);
      tick(); checkOutput("busy_start_done", observed(), doneV);
      tick(); checkOutput("held_idle_gap", observed(), idleV);
      bus.op_class = 3'd4;
      tick(); bus.start = 0;
      checkOutput("held_refetch", observed(), fetchV);
      tick();

      // MDR increment, class changed during EXEC
      tick(); checkOutput("mdr_exec", observed(), expv(2'd3, 2'd1, 3'd0, 0, 0, 1, 0, 0, 1, 0, 0));
      bus.op_class = 3'd0; bus.alu_func = 3'd3; #1;
      checkOutput("mdr_exec_hold", observed(), expv(2'd3, 2'd1, 3'd0, 0, 0, 1, 0, 0, 1, 0, 0));
      tick(); checkOutput("mdr_wb", observed(), wbV);
      tick(); checkOutput("mdr_done", observed(), doneV);
      tick();

      // reset and start on the same edge
      reset = 1; bus.start = 1;
      tick(); reset = 0; bus.start = 0;
      checkOutput("reset_vs_start", observed(), idleV);
      tick(); checkOutput("reset_vs_start_stay", observed(), idleV);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
